// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers (MTHI/MTLO capable).
// Optional build macro MDU_DIV0_FLAG_EN adds a DivZero output flagging divide-by-zero completions.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             HiWe,
  input  logic             LoWe,
  input  logic [WIDTH-1:0] WrData,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
`ifdef MDU_DIV0_FLAG_EN
  ,
  output logic             DivZero
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned DW    = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             is_div, is_div_d;
  logic             sign_a, sign_a_d;
  logic             sign_b, sign_b_d;
  logic             b_zero, b_zero_d;
  logic [WIDTH-1:0] a_raw, a_raw_d;
  logic [WIDTH-1:0] m, m_d;
  logic [DW-1:0]    acc, acc_d;
  logic [WIDTH-1:0] rem, rem_d;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             busy_d, done_d;
`ifdef MDU_DIV0_FLAG_EN
  logic             div0_d;
`endif

  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   part_rem;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  logic [DW-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
      a_raw  <= '0;
      m      <= '0;
      acc    <= '0;
      rem    <= '0;
      Hi     <= '0;
      Lo     <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
      DivZero <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      is_div <= is_div_d;
      sign_a <= sign_a_d;
      sign_b <= sign_b_d;
      b_zero <= b_zero_d;
      a_raw  <= a_raw_d;
      m      <= m_d;
      acc    <= acc_d;
      rem    <= rem_d;
      Hi     <= hi_d;
      Lo     <= lo_d;
      Busy   <= busy_d;
      Done   <= done_d;
`ifdef MDU_DIV0_FLAG_EN
      DivZero <= div0_d;
`endif
    end
  end

  // Next-state, iteration datapath and result formation
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    is_div_d = is_div;
    sign_a_d = sign_a;
    sign_b_d = sign_b;
    b_zero_d = b_zero;
    a_raw_d  = a_raw;
    m_d      = m;
    acc_d    = acc;
    rem_d    = rem;
    hi_d     = Hi;
    lo_d     = Lo;
    busy_d   = Busy;
    done_d   = 1'b0;
`ifdef MDU_DIV0_FLAG_EN
    div0_d   = 1'b0;
`endif

    a_abs    = (Op[0] && SrcA[WIDTH-1]) ? WIDTH'(-SrcA) : SrcA;
    b_abs    = (Op[0] && SrcB[WIDTH-1]) ? WIDTH'(-SrcB) : SrcB;
    // Multiply: conditionally add multiplicand to the upper half, then shift right
    mul_sum  = {1'b0, acc[DW-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    // Divide: shift next dividend bit into the partial remainder and trial-subtract
    part_rem = {rem, acc[WIDTH-1]};
    div_ge   = (part_rem >= {1'b0, m});
    div_sub  = WIDTH'(part_rem - {1'b0, m});
    prod_fix = (sign_a ^ sign_b) ? DW'(-acc) : acc;
    quo_fix  = (sign_a ^ sign_b) ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem_fix  = sign_a ? WIDTH'(-rem) : rem;

    case (state)
      IDLE: begin
        if (Start) begin
          is_div_d = Op[1];
          sign_a_d = Op[0] & SrcA[WIDTH-1];
          sign_b_d = Op[0] & SrcB[WIDTH-1];
          b_zero_d = (SrcB == '0);
          a_raw_d  = SrcA;
          m_d      = Op[1] ? b_abs : a_abs;
          acc_d    = {{WIDTH{1'b0}}, (Op[1] ? a_abs : b_abs)};
          rem_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = Op[1] ? DIV : MUL;
        end else begin
          if (HiWe) hi_d = WrData;
          if (LoWe) lo_d = WrData;
        end
      end
      MUL: begin
        acc_d = {mul_sum, acc[WIDTH-1:1]};
        cnt_d = CNT_W'(cnt + 1'b1);
        if (cnt == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      DIV: begin
        rem_d = div_ge ? div_sub : part_rem[WIDTH-1:0];
        acc_d = {acc[DW-1:WIDTH], acc[WIDTH-2:0], div_ge};
        cnt_d = CNT_W'(cnt + 1'b1);
        if (cnt == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (is_div) begin
          if (b_zero) begin
            hi_d = a_raw;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end else begin
          hi_d = prod_fix[DW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
`ifdef MDU_DIV0_FLAG_EN
        div0_d  = is_div & b_zero;
`endif
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: 64-bit arithmetic reference model, queue of expected results.
module tb_mult_div_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         Start = 1'b0;
  logic [1:0]   Op = 2'd0;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic         HiWe = 1'b0;
  logic         LoWe = 1'b0;
  logic [W-1:0] WrData = '0;
  logic         Busy, Done;
  logic [W-1:0] Hi, Lo;
`ifdef MDU_DIV0_FLAG_EN
  logic         DivZero;
`endif

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
    .HiWe(HiWe), .LoWe(LoWe), .WrData(WrData), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
`ifdef MDU_DIV0_FLAG_EN
    , .DivZero(DivZero)
`endif
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic, truncating division
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dz = 1'b0;
    e.cyc = 0;
    case (op)
      2'd0: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'd1: begin p = 64'(sa * sb); e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1;
        end else if (op == 2'd2) begin
          e.hi = a % b; e.lo = a / b;
        end else begin
          q = sa / sb; r = sa % sb;
          e.hi = 32'(r); e.lo = 32'(q);
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: every Done pulse pops the oldest expectation
  exp_t me;
  always @(negedge clk) begin
    if (rst_n && Done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected actual=Done required=no Done (t=%0t)", $time);
      end else begin
        me = exp_q.pop_front();
        chk("done_hi", 64'(Hi), 64'(me.hi));
        chk("done_lo", 64'(Lo), 64'(me.lo));
        chk("done_latency", 64'(cyc - me.cyc), 64'd34);
`ifdef MDU_DIV0_FLAG_EN
        chk("done_divzero", 64'(DivZero), 64'(me.dz));
`endif
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = model(op, a, b);
    e.cyc = cyc;
    exp_q.push_back(e);
    m_hi = e.hi;
    m_lo = e.lo;
    Start = 1'b1; Op = op; SrcA = a; SrcB = b;
  endtask

  // now=1 launches at the current negedge (e.g. the Done cycle of the previous op)
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit now, input bit disturb);
    logic [31:0] ph;
    logic [31:0] pl;
    int          bc;
    bit          seen;
    ph = m_hi; pl = m_lo; bc = 0; seen = 1'b0;
    if (!now) @(negedge clk);
    issue(op, a, b);
    @(negedge clk);
    Start = 1'b0; HiWe = 1'b0; LoWe = 1'b0;
    SrcA = $urandom; SrcB = $urandom; Op = 2'($urandom);
    for (int i = 0; i < 40 && !seen; i++) begin
      if (Busy) bc++;
      if (disturb && i == 10) begin
        Start = 1'b1; Op = 2'($urandom); LoWe = 1'b1; HiWe = 1'b1; WrData = 32'h1234_5678;
      end
      if (i == 11) begin Start = 1'b0; LoWe = 1'b0; HiWe = 1'b0; end
      if (i == 20) begin
        chk("busy_hold_hi", 64'(Hi), 64'(ph));
        chk("busy_hold_lo", 64'(Lo), 64'(pl));
      end
      if (Done) seen = 1'b1;
      else @(negedge clk);
    end
    chk("busy_cycles", 64'(bc), 64'd33);
    chk("done_seen", 64'(seen), 64'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nd;
    repeat (2) @(negedge clk);
    chk("reset_hi", 64'(Hi), 64'd0);
    chk("reset_lo", 64'(Lo), 64'd0);
    chk("reset_busy", 64'(Busy), 64'd0);
    chk("reset_done", 64'(Done), 64'd0);
    rst_n = 1'b1;

    run_op(2'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    chk("t1_hi", 64'(Hi), 64'h0000_0001);
    chk("t1_lo", 64'(Lo), 64'hFFFF_FFFE);
    run_op(2'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    chk("t2_mult_hi", 64'(Hi), 64'hFFFF_FFFF);
    chk("t2_mult_lo", 64'(Lo), 64'hFFFF_FFF1);
    run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
    chk("t2_multu_hi", 64'(Hi), 64'h0000_0004);
    chk("t2_multu_lo", 64'(Lo), 64'hFFFF_FFF1);
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("t3_div_lo", 64'(Lo), 64'hFFFF_FFFD);
    chk("t3_div_hi", 64'(Hi), 64'hFFFF_FFFF);
    run_op(2'd2, 32'd100, 32'd7, 1'b0, 1'b0);
    chk("t3_divu_lo", 64'(Lo), 64'h0000_000E);
    chk("t3_divu_hi", 64'(Hi), 64'h0000_0002);
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("t3_min_lo", 64'(Lo), 64'h8000_0000);
    chk("t3_min_hi", 64'(Hi), 64'h0);
    run_op(2'd2, 32'd7, 32'd0, 1'b0, 1'b0);
    chk("t4_divu0_hi", 64'(Hi), 64'h7);
    chk("t4_divu0_lo", 64'(Lo), 64'hFFFF_FFFF);
    run_op(2'd3, 32'd7, 32'd0, 1'b1, 1'b0);
    chk("t4_div0_hi", 64'(Hi), 64'h7);
    chk("t4_div0_lo", 64'(Lo), 64'hFFFF_FFFF);
    run_op(2'd3, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0);

    // Ignored Start and MTLO/MTHI while busy
    run_op(2'd1, 32'd1234, 32'hFFFF_FF00, 1'b0, 1'b1);

    // MTLO / MTHI in IDLE
    @(negedge clk);
    LoWe = 1'b1; WrData = 32'h1234_5678;
    @(negedge clk);
    LoWe = 1'b0; m_lo = 32'h1234_5678;
    chk("mtlo_idle", 64'(Lo), 64'h1234_5678);
    HiWe = 1'b1; WrData = 32'hCAFE_F00D;
    @(negedge clk);
    HiWe = 1'b0; m_hi = 32'hCAFE_F00D;
    chk("mthi_idle", 64'(Hi), 64'hCAFE_F00D);
    chk("mthi_keeps_lo", 64'(Lo), 64'h1234_5678);

    // Start together with a write: the write is dropped
    LoWe = 1'b1; HiWe = 1'b1; WrData = 32'hDEAD_BEEF;
    run_op(2'd0, 32'd6, 32'd7, 1'b1, 1'b0);
    chk("start_beats_we_lo", 64'(Lo), 64'd42);

    // Reset in the middle of a DIV
    @(negedge clk);
    issue(2'd3, 32'h8765_4321, 32'd13);
    @(negedge clk);
    Start = 1'b0;
    repeat (14) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_hi", 64'(Hi), 64'd0);
    chk("midreset_lo", 64'(Lo), 64'd0);
    chk("midreset_busy", 64'(Busy), 64'd0);
    exp_q.delete();
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done) nd++;
    end
    chk("no_done_after_reset", 64'(nd), 64'd0);
    run_op(2'd0, 32'd3, 32'd4, 1'b0, 1'b0);
    chk("post_reset_lo", 64'(Lo), 64'h0000_000C);

    // Randomized operations, some launched in the Done cycle
    for (int k = 0; k < 40; k++)
      run_op(2'($urandom), pick(), pick(), 1'($urandom), 1'($urandom_range(0, 3) == 0));

    @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
